// File: rtl/button_reader.sv
// Debounced active-low push-button reader: press/short/long pulses and a 0..2 colour-select mode.
// All outputs are registered; the raw pin only reaches logic through a 2-FF synchroniser.
module button_reader #(
    parameter int C_DEBOUNCE_COUNT = 120000,
    parameter int C_LONG_COUNT     = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Button_n,
    output logic       o_Pressed,
    output logic       o_Press,
    output logic       o_Short,
    output logic       o_Long,
    output logic [1:0] o_Mode
);

    localparam int DW = $clog2(C_DEBOUNCE_COUNT + 1);
    localparam int HW = $clog2(C_LONG_COUNT + 1);
    localparam logic [DW-1:0] DLAST = DW'(C_DEBOUNCE_COUNT - 1);
    localparam logic [HW-1:0] HMAX  = HW'(C_LONG_COUNT);
    localparam logic [HW-1:0] HLAST = HW'(C_LONG_COUNT - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          long_done;
    logic          flip;
    logic          rise;
    logic          fall;
    logic          db_next;
    logic          long_hit;

    // o_Pressed is the debounced state itself; edges are decoded from the pending flip
    // so that the pulses line up with the cycle the level changes.
    always_comb begin
        s        = ~sync2;
        flip     = (s != o_Pressed) && (dcnt == DLAST);
        rise     = flip && s;
        fall     = flip && !s;
        db_next  = flip ? s : o_Pressed;
        long_hit = db_next && (hcnt == HLAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            dcnt      <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            o_Pressed <= 1'b0;
            o_Press   <= 1'b0;
            o_Short   <= 1'b0;
            o_Long    <= 1'b0;
            o_Mode    <= 2'd0;
        end else begin
            sync1 <= i_Button_n;
            sync2 <= sync1;

            if ((s == o_Pressed) || flip)
                dcnt <= '0;
            else
                dcnt <= dcnt + 1'b1;

            o_Pressed <= db_next;
            o_Press   <= rise;
            o_Long    <= long_hit;
            o_Short   <= fall && !long_done;

            // The rising cycle counts as hold cycle 1, so hcnt tracks db_next.
            if (fall) begin
                hcnt      <= '0;
                long_done <= 1'b0;
            end else begin
                if (db_next && (hcnt != HMAX))
                    hcnt <= hcnt + 1'b1;
                if (long_hit)
                    long_done <= 1'b1;
            end

            if (long_hit)
                o_Mode <= 2'd0;
            else if (fall && !long_done)
                o_Mode <= (o_Mode == 2'd2) ? 2'd0 : o_Mode + 2'd1;
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: expected pulse events are queued when stimulus is driven
// and matched against events logged from the DUT outputs.
module tb_button_reader;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       o_Pressed;
    logic       o_Press;
    logic       o_Short;
    logic       o_Long;
    logic [1:0] o_Mode;

    button_reader #(.C_DEBOUNCE_COUNT(D), .C_LONG_COUNT(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_Button_n(pin),
        .o_Pressed (o_Pressed),
        .o_Press   (o_Press),
        .o_Short   (o_Short),
        .o_Long    (o_Long),
        .o_Mode    (o_Mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 press, 2 short, 3 long, 4 more than one pulse in a cycle
    typedef struct {
        int kind;
        int cyc;
        int mode;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_mode = 0;

    function automatic ev_t mk(input int kind, input int c, input int mode);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.mode = mode;
        return e;
    endfunction

    always @(negedge clk) begin
        if (int'(o_Press) + int'(o_Short) + int'(o_Long) > 1)
            obs_q.push_back(mk(4, cyc, int'(o_Mode)));
        else if (o_Press)
            obs_q.push_back(mk(1, cyc, int'(o_Mode)));
        else if (o_Short)
            obs_q.push_back(mk(2, cyc, int'(o_Mode)));
        else if (o_Long)
            obs_q.push_back(mk(3, cyc, int'(o_Mode)));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_sb(input string tag);
        int n;
        ev_t e;
        ev_t o;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_kind"}, o.kind, e.kind);
            chk({tag, "_cycle"}, o.cyc, e.cyc);
            chk({tag, "_mode"}, o.mode, e.mode);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Queue the events a clean press of n low samples (n >= D) must produce.
    task automatic push_press(input int n);
        int k;
        k = cyc + 1;
        exp_q.push_back(mk(1, k + D + 1, exp_mode));
        if (n >= L) begin
            exp_mode = 0;
            exp_q.push_back(mk(3, k + D + L, 0));
        end else begin
            exp_mode = (exp_mode + 1) % 3;
            exp_q.push_back(mk(2, k + n + D + 1, exp_mode));
        end
    endtask

    task automatic press(input int n, input int gap);
        push_press(n);
        pin = 1'b0;
        repeat (n) @(negedge clk);
        pin = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int m;
        int j;
        int k;

        rst_n = 1'b0;
        pin   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("rst_pressed", o_Pressed, 0);
            chk("rst_pulses", {o_Press, o_Short, o_Long}, 0);
            chk("rst_mode", o_Mode, 0);
        end
        check_sb("rst");

        pin = 1'b0;
        repeat (3) @(negedge clk);
        pin = 1'b1;
        @(negedge clk);
        pin = 1'b0;
        repeat (3) @(negedge clk);
        pin = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bounce_pressed", o_Pressed, 0);
        end
        check_sb("bounce");

        press(12, 12);
        chk("short_mode", o_Mode, exp_mode);
        check_sb("short");

        for (int i = 0; i < 4; i++) begin
            press(8, 12);
            chk("wrap_mode", o_Mode, exp_mode);
        end
        check_sb("wrap");

        chk("long_start_mode", o_Mode, exp_mode);
        pin = 1'b0;
        push_press(40);
        repeat (30) @(negedge clk);
        chk("long_held", o_Pressed, 1);
        repeat (10) @(negedge clk);
        pin = 1'b1;
        repeat (12) @(negedge clk);
        chk("long_mode", o_Mode, exp_mode);
        chk("long_released", o_Pressed, 0);
        check_sb("long");

        press(8, 12);
        chk("pre_reset_mode", o_Mode, exp_mode);
        check_sb("pre_reset");

        pin = 1'b0;
        k = cyc + 1;
        exp_q.push_back(mk(1, k + D + 1, exp_mode));
        repeat (10) @(negedge clk);
        chk("midrst_held", o_Pressed, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m = cyc;
        chk("midrst_pressed", o_Pressed, 0);
        chk("midrst_mode", o_Mode, 0);
        chk("midrst_pulses", {o_Press, o_Short, o_Long}, 0);
        exp_mode = 0;
        exp_q.push_back(mk(1, m + D + 2, 0));
        repeat (10) @(negedge clk);
        pin = 1'b1;
        j = cyc + 1;
        exp_mode = 1;
        exp_q.push_back(mk(2, j + D + 1, 1));
        repeat (12) @(negedge clk);
        chk("midrst_final_mode", o_Mode, exp_mode);
        check_sb("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
